// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch constants, redirect-select encoding and FSM states
`timescale 1ns/1ps
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  localparam int          EXC_ADEF_BIT = 0;
  localparam logic [1:0]  EXC_ADEF     = 2'(1 << EXC_ADEF_BIT);

  typedef enum logic [2:0] {
    REDIR_NONE   = 3'd0,
    REDIR_EXC    = 3'd1,
    REDIR_ERTN   = 3'd2,
    REDIR_BR_EXE = 3'd3,
    REDIR_BR_ID  = 3'd4
  } redir_sel_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } if_state_e;

  // Older pipeline stages win: an exception squashes any younger branch.
  function automatic redir_sel_e redir_select(input logic exc, input logic ertn,
                                              input logic br_exe, input logic br_id);
    if (exc)         return REDIR_EXC;
    else if (ertn)   return REDIR_ERTN;
    else if (br_exe) return REDIR_BR_EXE;
    else if (br_id)  return REDIR_BR_ID;
    else             return REDIR_NONE;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - fetch queue with registered storage, clear, and push-while-full-and-popping
`timescale 1ns/1ps
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Clear wins over push/pop so a flush never leaves a stale entry behind.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetch with redirect/discard; IF_ADEF_CHECK_EN enables ADEF check
`timescale 1ns/1ps
module if_prefetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH  = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        exc_flush,
  input  logic [31:0] exc_pc,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_pc,
  input  logic        br_taken_exe,
  input  logic [31:0] br_target_exe,
  input  logic        br_taken_id,
  input  logic [31:0] br_target_id,
  output logic        if_to_id_valid,
  input  logic        id_allowin,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [1:0]  if_exc
);

  localparam int         CW    = $clog2(FQ_DEPTH);
  localparam logic [2:0] MAX_O = 3'(MAX_OUTST);
`ifdef IF_ADEF_CHECK_EN
  localparam logic [1:0] EXC_MASK = EXC_ADEF;
`else
  localparam logic [1:0] EXC_MASK = 2'b00;
`endif

  logic [31:0]  fpc;
  logic [2:0]   outst;
  logic [2:0]   outst_next;
  logic [2:0]   discard;
  logic [2:0]   discard_next;
  if_state_e    state;
  logic [31:0]  pc_q [4];
  logic [1:0]   pc_wr;
  logic [1:0]   pc_rd;

  redir_sel_e   rsel;
  logic         redirect;
  logic [31:0]  redir_pc;
  logic         fire;
  logic         resp;
  logic         adef_push;
  logic         fetch_block;

  logic         fq_push;
  logic [65:0]  fq_data;
  logic [65:0]  fq_head;
  logic         fq_full;
  logic         fq_empty;
  logic [CW:0]  fq_count;
  logic [5:0]   inflight;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(MAX_OUTST - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    rsel     = redir_select(exc_flush, ertn_flush, br_taken_exe, br_taken_id);
    redirect = (rsel != REDIR_NONE);
    case (rsel)
      REDIR_EXC:    redir_pc = exc_pc;
      REDIR_ERTN:   redir_pc = ertn_pc;
      REDIR_BR_EXE: redir_pc = br_target_exe;
      REDIR_BR_ID:  redir_pc = br_target_id;
      default:      redir_pc = fpc;
    endcase
  end

`ifdef IF_ADEF_CHECK_EN
  logic adef_stop;
  logic fpc_misaligned;
  // The fault entry waits for older responses so ID still sees program order.
  assign fpc_misaligned = (fpc[1:0] != 2'b00);
  assign adef_push   = resetn && fpc_misaligned && !adef_stop && !redirect
                       && (outst == 3'd0) && !fq_full;
  assign fetch_block = fpc_misaligned || adef_stop;
`else
  assign adef_push   = 1'b0;
  assign fetch_block = 1'b0;
`endif

  // Outstanding requests reserve queue slots so every response has a home.
  assign inflight       = {3'b000, outst} + 6'(fq_count);
  assign inst_sram_req  = resetn && !redirect && !fetch_block && !fq_full
                          && (outst < MAX_O) && (inflight < 6'(FQ_DEPTH));
  assign inst_sram_addr = fpc;
  assign fire           = inst_sram_req && inst_sram_addr_ok;
  assign resp           = inst_sram_data_ok && (outst != 3'd0);

  always_comb begin
    outst_next = outst;
    case ({fire, resp})
      2'b10:   outst_next = outst + 3'd1;
      2'b01:   outst_next = outst - 3'd1;
      default: outst_next = outst;
    endcase
    discard_next = discard;
    if (redirect)
      discard_next = outst - {2'b00, resp};
    else if (resp && state == ST_DRAIN)
      discard_next = discard - 3'd1;
  end

  assign fq_push = (resp && !redirect && state == ST_RUN) || adef_push;
  assign fq_data = adef_push ? {fpc, 32'h0, EXC_ADEF}
                             : {pc_q[pc_rd], inst_sram_rdata, 2'b00};

  if_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (66)
  ) u_fq (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (redirect),
    .push      (fq_push),
    .push_data (fq_data),
    .pop       (id_allowin),
    .head      (fq_head),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count)
  );

  assign if_to_id_valid = !fq_empty;
  assign if_pc          = fq_empty ? 32'h0 : fq_head[65:34];
  assign if_inst        = fq_empty ? 32'h0 : fq_head[33:2];
  assign if_exc         = fq_empty ? 2'b00 : (fq_head[1:0] & EXC_MASK);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fpc     <= RESET_PC;
      outst   <= 3'd0;
      discard <= 3'd0;
      state   <= ST_RUN;
      pc_wr   <= 2'd0;
      pc_rd   <= 2'd0;
`ifdef IF_ADEF_CHECK_EN
      adef_stop <= 1'b0;
`endif
    end else begin
      if (redirect)  fpc <= redir_pc;
      else if (fire) fpc <= fpc + 32'd4;
      if (fire) begin
        pc_q[pc_wr] <= fpc;
        pc_wr       <= ptr_inc(pc_wr);
      end
      if (resp) pc_rd <= ptr_inc(pc_rd);
      outst   <= outst_next;
      discard <= discard_next;
      state   <= (discard_next != 3'd0) ? ST_DRAIN : ST_RUN;
`ifdef IF_ADEF_CHECK_EN
      if (redirect)       adef_stop <= 1'b0;
      else if (adef_push) adef_stop <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed scoreboard bench for if_prefetch with an SRAM responder model
`timescale 1ns/1ps
module tb_if_prefetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        exc_flush = 1'b0;
  logic [31:0] exc_pc = 32'h0;
  logic        ertn_flush = 1'b0;
  logic [31:0] ertn_pc = 32'h0;
  logic        br_taken_exe = 1'b0;
  logic [31:0] br_target_exe = 32'h0;
  logic        br_taken_id = 1'b0;
  logic [31:0] br_target_id = 32'h0;
  logic        if_to_id_valid;
  logic        id_allowin = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  if_exc;

  always #5 clk = ~clk;

  if_prefetch dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .exc_flush         (exc_flush),
    .exc_pc            (exc_pc),
    .ertn_flush        (ertn_flush),
    .ertn_pc           (ertn_pc),
    .br_taken_exe      (br_taken_exe),
    .br_target_exe     (br_target_exe),
    .br_taken_id       (br_taken_id),
    .br_target_id      (br_target_id),
    .if_to_id_valid    (if_to_id_valid),
    .id_allowin        (id_allowin),
    .if_pc             (if_pc),
    .if_inst           (if_inst),
    .if_exc            (if_exc)
  );

  typedef struct { logic [31:0] addr; int age; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [1:0] exc; } exp_t;

  pend_t       pend[$];
  exp_t        sb[$];
  int          lat = 1;
  bit          aok = 1'b1;
  logic [31:0] exp_fpc = 32'h1c00_0000;
  logic [31:0] last_pop_pc = 32'h0;
  int          n_pass = 0, n_fail = 0, n_total = 0;
  int          n_popped = 0, n_dropped = 0, n_req_cycles = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive SRAM response, observe handshakes mid-cycle, advance the model.
  task automatic step();
    bit          dlv, acc, redir;
    pend_t       p, np;
    exp_t        e;
    logic [31:0] tgt;
    dlv = (pend.size() > 0) && (pend[0].age >= lat);
    inst_sram_data_ok = dlv;
    inst_sram_rdata   = dlv ? data_of(pend[0].addr) : 32'h0;
    inst_sram_addr_ok = aok;
    #2;
    redir = exc_flush | ertn_flush | br_taken_exe | br_taken_id;
    acc = 1'b0;
    if (inst_sram_req) n_req_cycles++;
    if (redir) chk("req_on_redirect", {31'b0, inst_sram_req}, 32'h0);
    if (inst_sram_req && inst_sram_addr_ok) begin
      chk("fetch_addr", inst_sram_addr, exp_fpc);
      np.addr = inst_sram_addr; np.age = 0; np.stale = 1'b0;
      acc = 1'b1;
      exp_fpc = exp_fpc + 32'd4;
    end
    if (if_to_id_valid && id_allowin) begin
      if (sb.size() == 0) begin
        chk("id_unexpected_pc", if_pc, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        chk("id_pc", if_pc, e.pc);
        chk("id_inst", if_inst, e.inst);
        chk("id_exc", {30'b0, if_exc}, {30'b0, e.exc});
      end
      last_pop_pc = if_pc;
      n_popped++;
    end
    if (dlv) begin
      p = pend.pop_front();
      if (p.stale || redir) n_dropped++;
      else begin
        e.pc = p.addr; e.inst = data_of(p.addr); e.exc = 2'b00;
        sb.push_back(e);
      end
    end
    if (redir) begin
      if (exc_flush)         tgt = exc_pc;
      else if (ertn_flush)   tgt = ertn_pc;
      else if (br_taken_exe) tgt = br_target_exe;
      else                   tgt = br_target_id;
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
      sb.delete();
      exp_fpc = tgt;
    end
    if (acc) pend.push_back(np);
    @(posedge clk);
    #1;
    for (int i = 0; i < pend.size(); i++) pend[i].age = pend[i].age + 1;
  endtask

  task automatic wait_pop(input int base, input int budget);
    for (int i = 0; i < budget && n_popped == base; i++) step();
    chk("pop_within_budget", {31'b0, n_popped > base}, 32'h1);
  endtask

  initial begin
    int base, drop0, req0;

    // Reset, with a spurious data_ok that must be ignored
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hbad0_bad0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, inst_sram_req}, 32'h0);
    chk("rst_valid", {31'b0, if_to_id_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_if_exc", {30'b0, if_exc}, 32'h0);
    inst_sram_data_ok = 1'b0;
    resetn = 1'b1;
    id_allowin = 1'b1;
    #1;
    chk("first_req", {31'b0, inst_sram_req}, 32'h1);
    chk("first_addr", inst_sram_addr, 32'h1c00_0000);

    // Streaming fetch, one-cycle responses
    repeat (12) step();
    chk("stream_pops", {31'b0, n_popped >= 8}, 32'h1);

    // ID stalls: queue fills to depth and fetch stops
    id_allowin = 1'b0;
    repeat (10) step();
    chk("fill_entries", sb.size(), 32'd4);
    chk("fill_req_held", {31'b0, inst_sram_req}, 32'h0);
    chk("fill_valid", {31'b0, if_to_id_valid}, 32'h1);
    req0 = n_req_cycles;
    repeat (3) step();
    chk("fill_no_req", n_req_cycles - req0, 32'd0);
    id_allowin = 1'b1;
    repeat (8) step();

    // EXE branch with two requests in flight
    lat = 3;
    for (int i = 0; i < 12 && pend.size() != 2; i++) step();
    chk("two_outstanding", pend.size(), 32'd2);
    drop0 = n_dropped;
    br_taken_exe = 1'b1; br_target_exe = 32'h1c00_0100;
    step();
    br_taken_exe = 1'b0;
    base = n_popped;
    wait_pop(base, 30);
    chk("br_exe_first_pc", last_pop_pc, 32'h1c00_0100);
    chk("br_exe_dropped", n_dropped - drop0, 32'd2);

    // Exception and ID branch together: exception wins
    lat = 2;
    repeat (4) step();
    exc_flush = 1'b1; exc_pc = 32'h1c00_0800;
    br_taken_id = 1'b1; br_target_id = 32'h1c00_0400;
    step();
    exc_flush = 1'b0; br_taken_id = 1'b0;
    base = n_popped;
    wait_pop(base, 30);
    chk("exc_first_pc", last_pop_pc, 32'h1c00_0800);
    repeat (6) step();

    // Stop accepting, drain everything: nothing lost or duplicated
    aok = 1'b0;
    lat = 1;
    repeat (12) step();
    chk("drain_sb_empty", sb.size(), 32'd0);
    chk("drain_valid", {31'b0, if_to_id_valid}, 32'h0);
    chk("drain_exc_zero", {30'b0, if_exc}, 32'h0);

`ifdef IF_ADEF_CHECK_EN
    aok = 1'b1;
    ertn_flush = 1'b1; ertn_pc = 32'h1c00_0002;
    step();
    ertn_flush = 1'b0;
    begin
      exp_t e;
      e.pc = 32'h1c00_0002; e.inst = 32'h0; e.exc = 2'b01;
      sb.push_back(e);
    end
    req0 = n_req_cycles;
    base = n_popped;
    wait_pop(base, 10);
    repeat (5) step();
    chk("adef_pc", last_pop_pc, 32'h1c00_0002);
    chk("adef_no_req", n_req_cycles - req0, 32'd0);
    chk("adef_sb_empty", sb.size(), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries (power of 2, 2..16).
REQ-003 SHALL have parameter MAX_OUTST, default 2, maximum in-flight SRAM requests (1..4).
REQ-004 SHALL have ports: clk in 1 clock; resetn in 1 reset, synchronous, active-low.
REQ-005 SHALL have ports: inst_sram_req out 1 request valid; inst_sram_addr out 32 fetch address; inst_sram_addr_ok in 1 request accepted; inst_sram_data_ok in 1 response valid; inst_sram_rdata in 32 instruction.
REQ-006 SHALL have redirect inputs: exc_flush in 1 and exc_pc in 32; ertn_flush in 1 and ertn_pc in 32; br_taken_exe in 1 and br_target_exe in 32; br_taken_id in 1 and br_target_id in 32.
REQ-007 SHALL have ID-side ports: if_to_id_valid out 1; id_allowin in 1; if_pc out 32; if_inst out 32; if_exc out 2 (bit0 ADEF, bit1 reserved 0).

Function
REQ-008 SHALL hold fetch pointer fpc; a request issues when inst_sram_req && inst_sram_addr_ok, then fpc <= fpc+4 (32-bit wrap).
REQ-009 SHALL assert inst_sram_req only when outst < MAX_OUTST, (outst + fq_count) < FQ_DEPTH, and no redirect this cycle; inst_sram_addr = fpc.
REQ-010 SHALL keep a PC FIFO of MAX_OUTST entries holding the address of each accepted request, popped in order on data_ok.
REQ-011 SHALL push {pc, rdata, exc} into the fetch queue on each non-discarded data_ok, same cycle as the PC FIFO pop.
REQ-012 SHALL drive if_to_id_valid = queue non-empty; entry pops when if_to_id_valid && id_allowin; head fields are registered, no combinational SRAM-to-ID path.
REQ-013 SHALL support simultaneous push and pop when full; count unchanged.
REQ-014 SHALL apply redirect priority exc_flush > ertn_flush > br_taken_exe > br_taken_id; on redirect fpc <= selected target.
REQ-015 SHALL, on redirect, empty the fetch queue, set discard <= outst minus responses arriving that cycle, and drop the next discard data_ok responses.
REQ-016 SHALL decrement discard per dropped response; no response is pushed while discard != 0.
REQ-017 SHALL issue the first post-redirect request no earlier than the cycle after the redirect.
REQ-018 SHALL treat a redirect coinciding with an addr_ok as cancelling that request (counted into discard).
REQ-019 SHALL let the FSM states be RUN (normal) and DRAIN (discard != 0); requests to the new target are allowed in DRAIN; DRAIN -> RUN when discard reaches 0.

Reset
REQ-020 SHALL reset: fpc=RESET_PC, queue empty, outst=0, discard=0, state RUN, inst_sram_req=0, if_to_id_valid=0, if_pc=0, if_inst=0, if_exc=0.
REQ-021 SHALL ignore data_ok during reset and, after reset, issue the first request at RESET_PC in the first cycle resetn=1.

Configuration
REQ-022 SHALL with IF_ADEF_CHECK_EN defined: when fpc[1:0]!=0, issue no SRAM request; push {fpc, 32'h0, 2'b01} directly into the queue and stop fetching until redirect.
REQ-023 SHALL without IF_ADEF_CHECK_EN: fetch ignores fpc[1:0], and if_exc is constant 0.

Structure
REQ-024 SHALL place redirect-select encoding, the ADEF bit index and the RESET_PC default in shared package cpu_pkg.
REQ-025 SHALL implement the fetch queue as sub-module if_fifo (parameter DEPTH, WIDTH=66) with push/pop/full/empty/count.

Verification
REQ-026 SHALL verify: reset release, addr_ok=1 always, 1-cycle data_ok -> requests at 1c000000, 1c000004, ...; ID receives them in order.
REQ-027 SHALL verify: id_allowin=0 for 10 cycles -> queue fills to 4, inst_sram_req stays 0, no entry lost or duplicated.
REQ-028 SHALL verify: br_taken_exe to 1c000100 with 2 outstanding -> 2 responses dropped, next ID pc=1c000100.
REQ-029 SHALL verify: exc_flush (to 1c000800) and br_taken_id in the same cycle -> fetch resumes at 1c000800.
REQ-030 SHALL verify: with IF_ADEF_CHECK_EN, ertn_pc=1c000002 -> ID sees pc=1c000002, if_exc=2'b01, and no SRAM request is issued.
